// File: rtl/decode_cycle_if.sv
// rtl/decode_cycle_if.sv - ID-stage boundary bundle for decode_cycle
//
// Purpose: groups everything that crosses the decode stage boundary.
//   master : driven by the surrounding pipeline (fetch, write-back, hazard unit)
//   slave  : the decode stage itself
// Signals:
//   fetch in   : InstrD, PCD, PCPlus4D, Predict_branchD
//   WB in      : RegWriteW, RdW, ResultW
//   hazard     : FlushE (in), Rs1D/Rs2D (out, combinational)
//   ID/EX out  : RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
//                ALUControlE, BranchTypeE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
//                Rs1E, Rs2E, RdE, Predict_branchE, IllegalInstrE
interface decode_cycle_if #(
  parameter int XLEN = 32
);
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            Predict_branchD;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic            FlushE;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic            ALUSrcE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      ALUControlE;
  logic [2:0]      BranchTypeE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic            Predict_branchE;
  logic            IllegalInstrE;

  modport master (
    output InstrD, PCD, PCPlus4D, Predict_branchD, RegWriteW, RdW, ResultW, FlushE,
    input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE, BranchTypeE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, Predict_branchE, IllegalInstrE
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, Predict_branchD, RegWriteW, RdW, ResultW, FlushE,
    output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE, BranchTypeE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, Predict_branchE, IllegalInstrE
  );
endinterface

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage with register file and ID/EX register
//
// Purpose: decodes InstrD into controls and immediate, reads the 32x32 register
//   file (with same-cycle write-back bypass) and registers the result into ID/EX.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (clears ID/EX and the register file)
//   bus  : decode_cycle_if.slave (fetch/WB/flush inputs, Rs1D/Rs2D, all E outputs)
// Build option:
//   DECODE_ILLEGAL_TRAP_EN - when defined, IllegalInstrE flags a non-zero
//   instruction with an unsupported opcode; otherwise IllegalInstrE is tied 0.
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic           clk,
  input logic           rst,
  decode_cycle_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  assign instr  = bus.InstrD;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  assign bus.Rs1D = rs1;
  assign bus.Rs2D = rs2;

  // Register file; x0 is never written and also masked on read.
  logic [XLEN-1:0] regFile [NREGS];
  logic            wbWrite;

  assign wbWrite = bus.RegWriteW && (bus.RdW != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
    end else if (wbWrite) begin
      regFile[bus.RdW] <= bus.ResultW;
    end
  end

  // Bypass: the WB value written at this edge is what the instruction must see.
  logic [XLEN-1:0] rd1Raw, rd2Raw;

  always_comb begin
    rd1Raw = '0;
    rd2Raw = '0;
    if (rs1 != 5'd0) rd1Raw = (wbWrite && bus.RdW == rs1) ? bus.ResultW : regFile[rs1];
    if (rs2 != 5'd0) rd2Raw = (wbWrite && bus.RdW == rs2) ? bus.ResultW : regFile[rs2];
  end

  // Immediates, sign-extended from instr[31].
  logic [XLEN-1:0] immI, immS, immB, immJ, immU;

  assign immI = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign immS = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign immB = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immJ = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign immU = {instr[31:12], 12'b0};

  // funct3 -> ALU op; sltu shares the slt encoding since there is no unsigned compare op.
  function automatic logic [2:0] aluFromFunct3(input logic [2:0] f3);
    case (f3)
      3'b000:  return 3'b000;
      3'b001:  return 3'b110;
      3'b010:  return 3'b101;
      3'b011:  return 3'b101;
      3'b100:  return 3'b100;
      3'b101:  return 3'b111;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  logic            regWriteD, memWriteD, jumpD, branchD, aluSrcD, zeroRd1D;
  logic [1:0]      resultSrcD;
  logic [2:0]      aluControlD, branchTypeD;
  logic [XLEN-1:0] immExtD;

  always_comb begin
    regWriteD   = 1'b0;
    memWriteD   = 1'b0;
    jumpD       = 1'b0;
    branchD     = 1'b0;
    aluSrcD     = 1'b0;
    zeroRd1D    = 1'b0;
    resultSrcD  = 2'b00;
    aluControlD = 3'b000;
    branchTypeD = 3'b000;
    immExtD     = '0;
    case (opcode)
      OP_LOAD: begin
        regWriteD  = 1'b1;
        aluSrcD    = 1'b1;
        resultSrcD = 2'b01;
        immExtD    = immI;
      end
      OP_STORE: begin
        memWriteD = 1'b1;
        aluSrcD   = 1'b1;
        immExtD   = immS;
      end
      OP_RTYPE: begin
        regWriteD   = 1'b1;
        aluControlD = (funct3 == 3'b000 && instr[30]) ? 3'b001 : aluFromFunct3(funct3);
      end
      OP_IALU: begin
        // instr[30] is immediate data here, so no sub selection.
        regWriteD   = 1'b1;
        aluSrcD     = 1'b1;
        aluControlD = aluFromFunct3(funct3);
        immExtD     = immI;
      end
      OP_BRANCH: begin
        branchD     = 1'b1;
        aluControlD = 3'b001;
        branchTypeD = funct3;
        immExtD     = immB;
      end
      OP_JAL: begin
        regWriteD  = 1'b1;
        jumpD      = 1'b1;
        resultSrcD = 2'b10;
        immExtD    = immJ;
      end
      OP_LUI: begin
        regWriteD = 1'b1;
        aluSrcD   = 1'b1;
        zeroRd1D  = 1'b1;
        immExtD   = immU;
      end
      default: ;
    endcase
  end

  // ID/EX register: loads every cycle; rst and FlushE both load a bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushE) begin
      bus.RegWriteE       <= 1'b0;
      bus.MemWriteE       <= 1'b0;
      bus.JumpE           <= 1'b0;
      bus.BranchE         <= 1'b0;
      bus.ALUSrcE         <= 1'b0;
      bus.ResultSrcE      <= 2'b00;
      bus.ALUControlE     <= 3'b000;
      bus.BranchTypeE     <= 3'b000;
      bus.RD1E            <= '0;
      bus.RD2E            <= '0;
      bus.ImmExtE         <= '0;
      bus.PCE             <= '0;
      bus.PCPlus4E        <= '0;
      bus.Rs1E            <= 5'd0;
      bus.Rs2E            <= 5'd0;
      bus.RdE             <= 5'd0;
      bus.Predict_branchE <= 1'b0;
    end else begin
      bus.RegWriteE       <= regWriteD;
      bus.MemWriteE       <= memWriteD;
      bus.JumpE           <= jumpD;
      bus.BranchE         <= branchD;
      bus.ALUSrcE         <= aluSrcD;
      bus.ResultSrcE      <= resultSrcD;
      bus.ALUControlE     <= aluControlD;
      bus.BranchTypeE     <= branchTypeD;
      bus.RD1E            <= zeroRd1D ? '0 : rd1Raw;
      bus.RD2E            <= rd2Raw;
      bus.ImmExtE         <= immExtD;
      bus.PCE             <= bus.PCD;
      bus.PCPlus4E        <= bus.PCPlus4D;
      bus.Rs1E            <= rs1;
      bus.Rs2E            <= rs2;
      bus.RdE             <= rd;
      bus.Predict_branchE <= bus.Predict_branchD;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic supportedOp;

  assign supportedOp = (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                       (opcode == OP_RTYPE)  || (opcode == OP_IALU)  ||
                       (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
                       (opcode == OP_LUI);

  // All-zero instruction is the fetch bubble, not a trap.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushE) bus.IllegalInstrE <= 1'b0;
    else                   bus.IllegalInstrE <= (instr != 32'd0) && !supportedOp;
  end
`else
  assign bus.IllegalInstrE = 1'b0;
`endif

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - self-checking bench for decode_cycle
module tb_decode_cycle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_cycle_if #(.XLEN(32)) bus();

  decode_cycle #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nVec  = 0;
  int nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural model: register contents plus the ID/EX record an instruction produces.
  typedef struct packed {
    logic        regWrite, memWrite, jump, branch, aluSrc;
    logic [1:0]  resultSrc;
    logic [2:0]  aluCtl, brType;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        pred, illegal;
  } idex_t;

  logic [31:0] mrf [32];
  idex_t       exp;
  bit          armed = 0;
  logic [2:0]  aluOfF3 [8] = '{3'd0, 3'd6, 3'd5, 3'd5, 3'd4, 3'd7, 3'd3, 3'd2};

  function automatic idex_t decodeModel(input logic [31:0] i, input logic [31:0] pc,
                                        input logic [31:0] pc4, input logic pred);
    idex_t e;
    int    s;
    e       = '0;
    e.rs1   = i[19:15];
    e.rs2   = i[24:20];
    e.rd    = i[11:7];
    e.rd1   = mrf[i[19:15]];
    e.rd2   = mrf[i[24:20]];
    e.pc    = pc;
    e.pc4   = pc4;
    e.pred  = pred;
    case (i[6:0])
      7'h03: begin
        e.regWrite = 1; e.aluSrc = 1; e.resultSrc = 2'd1;
        s = $signed(i[31:20]); e.imm = s;
      end
      7'h23: begin
        e.memWrite = 1; e.aluSrc = 1;
        s = $signed({i[31:25], i[11:7]}); e.imm = s;
      end
      7'h33: begin
        e.regWrite = 1;
        e.aluCtl = (i[14:12] == 3'd0 && i[30]) ? 3'd1 : aluOfF3[i[14:12]];
      end
      7'h13: begin
        e.regWrite = 1; e.aluSrc = 1; e.aluCtl = aluOfF3[i[14:12]];
        s = $signed(i[31:20]); e.imm = s;
      end
      7'h63: begin
        e.branch = 1; e.aluCtl = 3'd1; e.brType = i[14:12];
        s = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); e.imm = s;
      end
      7'h6F: begin
        e.regWrite = 1; e.jump = 1; e.resultSrc = 2'd2;
        s = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); e.imm = s;
      end
      7'h37: begin
        e.regWrite = 1; e.aluSrc = 1; e.rd1 = 0;
        e.imm = i[31:12] * 32'd4096;
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        e.illegal = (i != 0);
`endif
      end
    endcase
    return e;
  endfunction

  // Model update at each edge: registers hold the post-writeback state, which is
  // exactly what a same-cycle reader must observe.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) mrf[k] = 0;
      exp = '0;
    end else begin
      if (bus.RegWriteW && bus.RdW != 0) mrf[bus.RdW] = bus.ResultW;
      exp = bus.FlushE ? idex_t'(0) : decodeModel(bus.InstrD, bus.PCD, bus.PCPlus4D, bus.Predict_branchD);
    end
    armed = 1;
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      check("RegWriteE", 32'(bus.RegWriteE), 32'(exp.regWrite));
      check("MemWriteE", 32'(bus.MemWriteE), 32'(exp.memWrite));
      check("JumpE", 32'(bus.JumpE), 32'(exp.jump));
      check("BranchE", 32'(bus.BranchE), 32'(exp.branch));
      check("ALUSrcE", 32'(bus.ALUSrcE), 32'(exp.aluSrc));
      check("ResultSrcE", 32'(bus.ResultSrcE), 32'(exp.resultSrc));
      check("ALUControlE", 32'(bus.ALUControlE), 32'(exp.aluCtl));
      check("BranchTypeE", 32'(bus.BranchTypeE), 32'(exp.brType));
      check("RD1E", bus.RD1E, exp.rd1);
      check("RD2E", bus.RD2E, exp.rd2);
      check("ImmExtE", bus.ImmExtE, exp.imm);
      check("PCE", bus.PCE, exp.pc);
      check("PCPlus4E", bus.PCPlus4E, exp.pc4);
      check("Rs1E", 32'(bus.Rs1E), 32'(exp.rs1));
      check("Rs2E", 32'(bus.Rs2E), 32'(exp.rs2));
      check("RdE", 32'(bus.RdE), 32'(exp.rd));
      check("Predict_branchE", 32'(bus.Predict_branchE), 32'(exp.pred));
      check("IllegalInstrE", 32'(bus.IllegalInstrE), 32'(exp.illegal));
    end
  end

  task automatic apply(input logic r, input logic flush, input logic [31:0] instr,
                       input logic [31:0] pc, input logic pred,
                       input logic we, input logic [4:0] rdw, input logic [31:0] res);
    @(negedge clk);
    rst                 = r;
    bus.FlushE          = flush;
    bus.InstrD          = instr;
    bus.PCD             = pc;
    bus.PCPlus4D        = pc + 32'd4;
    bus.Predict_branchD = pred;
    bus.RegWriteW       = we;
    bus.RdW             = rdw;
    bus.ResultW         = res;
    #1;
    check("Rs1D", 32'(bus.Rs1D), 32'(instr[19:15]));
    check("Rs2D", 32'(bus.Rs2D), 32'(instr[24:20]));
    @(posedge clk);
    #1;
  endtask

  logic expIll;

  initial begin
    bus.InstrD = 0; bus.PCD = 0; bus.PCPlus4D = 0; bus.Predict_branchD = 0;
    bus.RegWriteW = 0; bus.RdW = 0; bus.ResultW = 0; bus.FlushE = 0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    expIll = 1'b1;
`else
    expIll = 1'b0;
`endif

    apply(1, 0, 32'h002081B3, 32'h0, 0, 0, 0, 0);
    apply(1, 0, 32'h002081B3, 32'h0, 0, 0, 0, 0);
    check("lit reset RegWriteE", 32'(bus.RegWriteE), 32'd0);
    check("lit reset RdE", 32'(bus.RdE), 32'd0);

    apply(0, 0, 32'h00000000, 32'h0, 0, 1, 5'd5, 32'h0000FFFF);
    apply(0, 0, 32'h00028333, 32'h4, 0, 0, 0, 0);
    check("lit read x5", bus.RD1E, 32'h0000FFFF);
    check("lit add rd", 32'(bus.RdE), 32'd6);

    apply(0, 0, 32'h00500093, 32'h8, 0, 0, 0, 0);
    check("lit addi RegWriteE", 32'(bus.RegWriteE), 32'd1);
    check("lit addi ALUSrcE", 32'(bus.ALUSrcE), 32'd1);
    check("lit addi ImmExtE", bus.ImmExtE, 32'd5);
    check("lit addi RdE", 32'(bus.RdE), 32'd1);
    check("lit addi ALUControlE", 32'(bus.ALUControlE), 32'd0);

    apply(0, 0, 32'h002081B3, 32'hC, 0, 1, 5'd1, 32'h00001234);
    check("lit bypass RD1E", bus.RD1E, 32'h00001234);
    check("lit bypass Rs1E", 32'(bus.Rs1E), 32'd1);
    check("lit bypass RdE", 32'(bus.RdE), 32'd3);

    apply(0, 0, 32'h002081B3, 32'h10, 0, 1, 5'd2, 32'h00000077);
    check("lit bypass RD2E", bus.RD2E, 32'h00000077);
    check("lit stored RD1E", bus.RD1E, 32'h00001234);

    apply(0, 0, 32'h010000EF, 32'h40, 1, 0, 0, 0);
    check("lit jal JumpE", 32'(bus.JumpE), 32'd1);
    check("lit jal ResultSrcE", 32'(bus.ResultSrcE), 32'd2);
    check("lit jal ImmExtE", bus.ImmExtE, 32'd16);
    check("lit jal PCE", bus.PCE, 32'h40);
    check("lit jal PCPlus4E", bus.PCPlus4E, 32'h44);
    check("lit jal Predict_branchE", 32'(bus.Predict_branchE), 32'd1);

    apply(0, 1, 32'h010000EF, 32'h40, 1, 0, 0, 0);
    check("lit flush JumpE", 32'(bus.JumpE), 32'd0);
    check("lit flush PCE", bus.PCE, 32'd0);
    check("lit flush Predict_branchE", 32'(bus.Predict_branchE), 32'd0);
    check("lit flush ImmExtE", bus.ImmExtE, 32'd0);

    apply(0, 0, 32'h000003B3, 32'h44, 0, 1, 5'd0, 32'h0000DEAD);
    check("lit x0 bypass RD1E", bus.RD1E, 32'd0);
    apply(0, 0, 32'h000003B3, 32'h48, 0, 0, 0, 0);
    check("lit x0 read RD1E", bus.RD1E, 32'd0);

    apply(0, 0, 32'h40508233, 32'h4C, 0, 0, 0, 0);
    check("lit sub ALUControlE", 32'(bus.ALUControlE), 32'd1);
    check("lit sub RD2E", bus.RD2E, 32'h0000FFFF);

    apply(0, 0, 32'hFFC0A403, 32'h50, 0, 0, 0, 0);
    check("lit lw ImmExtE", bus.ImmExtE, 32'hFFFFFFFC);
    check("lit lw ResultSrcE", 32'(bus.ResultSrcE), 32'd1);

    apply(0, 0, 32'h0050A423, 32'h54, 0, 0, 0, 0);
    check("lit sw ImmExtE", bus.ImmExtE, 32'd8);
    check("lit sw MemWriteE", 32'(bus.MemWriteE), 32'd1);

    apply(0, 0, 32'hFE509CE3, 32'h58, 1, 0, 0, 0);
    check("lit bne ImmExtE", bus.ImmExtE, 32'hFFFFFFF8);
    check("lit bne BranchTypeE", 32'(bus.BranchTypeE), 32'd1);

    apply(0, 0, 32'h123454B7, 32'h5C, 0, 1, 5'd8, 32'h00005555);
    check("lit lui ImmExtE", bus.ImmExtE, 32'h12345000);
    check("lit lui RD1E", bus.RD1E, 32'd0);

    apply(0, 0, 32'hFFF2C513, 32'h60, 0, 0, 0, 0);
    check("lit xori ALUControlE", 32'(bus.ALUControlE), 32'd4);
    check("lit xori ImmExtE", bus.ImmExtE, 32'hFFFFFFFF);

    apply(0, 0, 32'h40000093, 32'h64, 0, 0, 0, 0);
    check("lit addi bit30 ALUControlE", 32'(bus.ALUControlE), 32'd0);
    check("lit addi bit30 ImmExtE", bus.ImmExtE, 32'h00000400);

    apply(0, 0, 32'h0000007F, 32'h68, 0, 0, 0, 0);
    check("lit illegal IllegalInstrE", 32'(bus.IllegalInstrE), 32'(expIll));
    check("lit illegal RegWriteE", 32'(bus.RegWriteE), 32'd0);

    apply(0, 0, 32'h00000000, 32'h6C, 0, 0, 0, 0);
    check("lit zero IllegalInstrE", 32'(bus.IllegalInstrE), 32'd0);

    apply(1, 0, 32'h00000000, 32'h0, 0, 0, 0, 0);
    apply(0, 0, 32'h00028333, 32'h0, 0, 0, 0, 0);
    check("lit reset clears x5", bus.RD1E, 32'd0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Decode stage of the 5-stage RV32I pipeline. Consumes InstrD/PCD/PCPlus4D/Predict_branchD from the fetch stage's IF/ID register. Decodes control, generates the immediate, reads the 32x32 register file with write-back bypass, and registers everything into the ID/EX register. Accepts WB-stage writes and exposes source register indices to the hazard unit.

Parameters:
XLEN, 32, datapath width
NREGS, 32, register file depth (x0 hardwired zero)

Ports:
clk  in  1  clock, posedge only
rst  in  1  reset, synchronous, active-high
InstrD  in  32  instruction from fetch
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
Predict_branchD  in  1  fetch-stage taken prediction for InstrD
RegWriteW  in  1  WB write enable
RdW  in  5  WB destination
ResultW  in  32  WB data
FlushE  in  1  squash ID/EX (insert bubble)
Rs1D, Rs2D  out  5  combinational InstrD[19:15], [24:20] to hazard unit
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered controls
ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
BranchTypeE  out  3  funct3 of branch
RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32  registered data
Rs1E, Rs2E, RdE  out  5  registered indices
Predict_branchE  out  1  registered prediction
IllegalInstrE  out  1  see Optional Feature

Behaviour:
- Reset: posedge clk with rst=1 clears every ID/EX output to 0 and every register file entry to 0. rst takes priority over all inputs.
- Latency: one cycle. Values decoded from InstrD at edge N appear on the E outputs after edge N. The block has no stall input; the ID/EX register loads every cycle.
- FlushE=1 (rst=0): at the edge, load all ID/EX fields with 0. A zero field set is a bubble with no side effects. FlushE overrides a valid InstrD.
- Supported opcodes:
  - 0000011 lw: RegWrite, ALUSrc, ResultSrc=01, imm I.
  - 0100011 sw: MemWrite, ALUSrc, imm S.
  - 0110011 R-type: RegWrite. ALUControl from funct3; funct7[5]=1 with funct3=000 selects sub.
  - 0010011 I-ALU: RegWrite, ALUSrc, imm I.
  - 1100011 branch: Branch, ALUControl=sub, BranchType=funct3, imm B.
  - 1101111 jal: RegWrite, Jump, ResultSrc=10, imm J.
  - 0110111 lui: RegWrite, ALUSrc, ALUControl=add, imm U, RD1 forced 0.
- Any other opcode, including InstrD=0: all controls 0.
- Immediates are sign-extended from bit 31. B and J immediates have bit0=0. U immediate is {instr[31:12],12'b0}.
- Register file write: at posedge when RegWriteW=1 and RdW!=0. A write to x0 is ignored and a read of x0 returns 0.
- Write-back bypass: when RegWriteW=1, RdW!=0 and RdW equals Rs1D (resp. Rs2D), RD1 (resp. RD2) takes ResultW in the same cycle.
- Rs1D/Rs2D are driven raw, regardless of whether the opcode uses them.
- Predict_branchE is carried unchanged. It is cleared by rst or FlushE.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN
- Defined: IllegalInstrE is registered as 1 when InstrD!=0 and the opcode is unsupported. It is cleared by rst/FlushE. The instruction still decodes to a bubble.
- Undefined: IllegalInstrE is tied to 0 and no detection logic is built.

Test Plan:
- rst=1 for 2 cycles while InstrD=0x002081B3 -> all E outputs 0. Then write x5=0xFFFF via WB -> read of x5 returns 0xFFFF.
- InstrD=0x00500093 (addi x1,x0,5) -> next cycle RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000.
- WB RegWriteW=1, RdW=1, ResultW=0x1234 in the same cycle as InstrD=0x002081B3 (add x3,x1,x2) -> RD1E=0x1234, Rs1E=1, RdE=3.
- InstrD=0x010000EF (jal x1,16), PCD=0x40, Predict_branchD=1 -> JumpE=1, ResultSrcE=10, ImmExtE=16, PCE=0x40, Predict_branchE=1. The same stimulus with FlushE=1 -> all E outputs 0.
- WB write RdW=0, ResultW=0xDEAD, then InstrD reads x0 -> RD1E=0.
- With DECODE_ILLEGAL_TRAP_EN: InstrD=0x0000007F -> IllegalInstrE=1, RegWriteE=0. InstrD=0 -> IllegalInstrE=0. Without the macro -> IllegalInstrE stays 0.
